// File: rtl/fence_sequencer_if.sv
// ---------------------------------------------------------------------------
// fence_sequencer_if
// Bundles the decode, load/store unit and PC-control signals that surround the
// fence sequencer. Clock and reset stay outside as plain ports.
//
// Signals (direction as seen by the sequencer, i.e. the slave modport):
//   fence_req    in   decode presents a fence (looked at only while idle)
//   fence_i      in   fence_req is a FENCE.I
//   fence_pred   in   FENCE predecessor set {I,O,R,W}
//   pc           in   PC of the fence instruction
//   mem_issue    in   one memory op issued this cycle
//   mem_done     in   one memory op completed this cycle
//   flush_ack    in   instruction buffer flush complete
//   stall        out  hold fetch/decode
//   fence        out  fence active to PC control
//   mem_block    out  LSU must not issue
//   flush_req    out  request instruction-buffer flush
//   pc_load      out  one-cycle PC reload strobe
//   resume_pc    out  PC to load while pc_load is high
//   outstanding  out  in-flight memory op count
//   err_ovf      out  sticky counter misuse flag
//   err_timeout  out  sticky drain timeout flag
// ---------------------------------------------------------------------------
interface fence_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             fence_req;
    logic             fence_i;
    logic [3:0]       fence_pred;
    logic [31:0]      pc;
    logic             mem_issue;
    logic             mem_done;
    logic             flush_ack;

    logic             stall;
    logic             fence;
    logic             mem_block;
    logic             flush_req;
    logic             pc_load;
    logic [31:0]      resume_pc;
    logic [CNT_W-1:0] outstanding;
    logic             err_ovf;
    logic             err_timeout;

    // Environment side: decode, LSU and instruction buffer.
    modport master (
        output fence_req, fence_i, fence_pred, pc, mem_issue, mem_done, flush_ack,
        input  stall, fence, mem_block, flush_req, pc_load, resume_pc,
               outstanding, err_ovf, err_timeout
    );

    // Sequencer side.
    modport slave (
        input  fence_req, fence_i, fence_pred, pc, mem_issue, mem_done, flush_ack,
        output stall, fence, mem_block, flush_req, pc_load, resume_pc,
               outstanding, err_ovf, err_timeout
    );
endinterface

// File: rtl/fence_sequencer.sv
// ---------------------------------------------------------------------------
// fence_sequencer
// Handles FENCE / FENCE.I around the PC-control datapath. It counts in-flight
// memory ops, stalls fetch and drains memory while a fence with a non-empty
// predecessor set is pending, requests an instruction-buffer flush for
// FENCE.I, and finally strobes a PC reload to the word-indexed successor
// (saved pc + 1).
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset; aborts any fence in progress
//   bus    fence_sequencer_if.slave (decode / LSU / flush / PC-control signals)
//
// Parameters:
//   MAX_OUTSTANDING  in-flight op limit (1..15)
//   CNT_W            outstanding counter width, must hold MAX_OUTSTANDING
//   DRAIN_TIMEOUT    cycles allowed in DRAIN before a forced exit (1..255)
// ---------------------------------------------------------------------------
module fence_sequencer #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 4,
    parameter int DRAIN_TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    fence_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        FLUSH  = 2'd2,
        RESUME = 2'd3
    } state_t;

    // Fence context captured when decode presents the instruction.
    typedef struct packed {
        logic        fence_i;
        logic [31:0] pc;
    } fence_ctx_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [7:0]       TO_LAST = 8'(DRAIN_TIMEOUT - 1);

    state_t           state, state_nxt;
    fence_ctx_t       ctx;
    logic [CNT_W-1:0] count;
    logic [7:0]       tcnt;
    logic [31:0]      resume_pc;
    logic             err_ovf;
    logic             err_timeout;

    logic             drain_exit;
    logic             drain_to;
    logic             issue_only;
    logic             done_only;
    logic             cnt_inc;
    logic             cnt_dec;
    logic             cnt_err;

    // ------------------------------------------------------------------
    // Outstanding counter. Simultaneous issue and done cancel, which also
    // makes them legal at either boundary.
    // ------------------------------------------------------------------
    assign issue_only = bus.mem_issue & ~bus.mem_done;
    assign done_only  = bus.mem_done  & ~bus.mem_issue;
    assign cnt_inc    = issue_only & (count != CNT_MAX);
    assign cnt_dec    = done_only  & (count != '0);
    assign cnt_err    = (issue_only & (count == CNT_MAX)) |
                        (done_only  & (count == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            err_ovf <= 1'b0;
        end else begin
            if (cnt_inc)
                count <= count + CNT_W'(1);
            else if (cnt_dec)
                count <= count - CNT_W'(1);
            if (cnt_err)
                err_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. DRAIN decisions use the count registered at the
    // start of the cycle, not the value being written this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        drain_exit = 1'b0;
        drain_to   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fence_req) begin
                    if (bus.fence_pred != 4'd0)
                        state_nxt = DRAIN;
                    else if (bus.fence_i)
                        state_nxt = FLUSH;
                    else
                        state_nxt = RESUME;
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    drain_exit = 1'b1;
                end else if (tcnt == TO_LAST) begin
                    drain_exit = 1'b1;
                    drain_to   = 1'b1;
                end
                if (drain_exit)
                    state_nxt = ctx.fence_i ? FLUSH : RESUME;
            end
            FLUSH: begin
                if (bus.flush_ack)
                    state_nxt = RESUME;
            end
            RESUME: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, captured context, drain timer and reload address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ctx         <= '0;
            tcnt        <= '0;
            resume_pc   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && bus.fence_req) begin
                ctx.fence_i <= bus.fence_i;
                ctx.pc      <= bus.pc;
            end

            // Timer restarts on every entry to DRAIN; it cannot wrap because
            // the forced exit fires at DRAIN_TIMEOUT-1 (at most 254).
            if (state != DRAIN && state_nxt == DRAIN)
                tcnt <= '0;
            else if (state == DRAIN)
                tcnt <= tcnt + 8'd1;

            // Loaded only on entry to RESUME so it holds until the next one.
            // Coming straight from IDLE the context register is not yet
            // written, so take the PC from the bus.
            if (state_nxt == RESUME && state != RESUME)
                resume_pc <= ((state == IDLE) ? bus.pc : ctx.pc) + 32'd1;

            if (drain_to)
                err_timeout <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: Moore decode of the registered state, except mem_block.
    // ------------------------------------------------------------------
    assign bus.stall       = (state != IDLE);
    assign bus.fence       = (state == DRAIN) || (state == FLUSH);
    assign bus.flush_req   = (state == FLUSH);
    assign bus.pc_load     = (state == RESUME);
    assign bus.resume_pc   = resume_pc;
    assign bus.outstanding = count;
    assign bus.err_ovf     = err_ovf;
    assign bus.err_timeout = err_timeout;
    assign bus.mem_block   = (count == CNT_MAX) || (state == DRAIN);

endmodule

// File: doc/fence_sequencer.md
Name: fence_sequencer

Overview:
Sequences FENCE / FENCE.I handling around the PC-control datapath. It tracks outstanding memory operations, stalls fetch and drains memory while a fence is pending, and requests an instruction-buffer flush for FENCE.I. It then reloads the PC with the word-indexed successor address (pc + 1). It sits between decode, the load/store unit and the PC-control block, driving that block's fence input.

Parameters:
MAX_OUTSTANDING, 8, maximum in-flight memory ops tracked; 1..15
CNT_W, 4, width of outstanding counter; must hold MAX_OUTSTANDING
DRAIN_TIMEOUT, 255, max cycles spent in DRAIN before forced exit; 1..255

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
fence_req  in  1  decode presents a fence this cycle; sampled only in IDLE
fence_i  in  1  qualifies fence_req as FENCE.I; sampled with fence_req
fence_pred  in  4  FENCE predecessor set {I,O,R,W}; sampled with fence_req
pc  in  32  PC of the fence instruction; sampled with fence_req
mem_issue  in  1  one memory op issued this cycle
mem_done  in  1  one memory op completed this cycle
flush_ack  in  1  instruction buffer flush complete
stall  out  1  hold fetch/decode
fence  out  1  fence active to PC control
mem_block  out  1  LSU must not issue; count == MAX_OUTSTANDING or state == DRAIN
flush_req  out  1  request instruction-buffer flush
pc_load  out  1  one-cycle PC reload strobe
resume_pc  out  32  PC value to load when pc_load is high
outstanding  out  CNT_W  current in-flight memory op count
err_ovf  out  1  sticky: issue at full count, or done at zero
err_timeout  out  1  sticky: DRAIN exited by timeout

Behaviour:
- The clock port is clk and the reset port is reset: one clock, asynchronous active-high reset. While reset is high: state = IDLE. All outputs, the saved PC, the saved flags and the timeout counter are 0. Reset mid-fence aborts the sequence with no pc_load.
- Outstanding counter, updated every cycle in every state:
  - issue only: +1.
  - done only: −1.
  - both together: unchanged.
  - issue while count == MAX_OUTSTANDING: count held, err_ovf set.
  - done while count == 0: count held, err_ovf set.
  - issue and done together at either boundary: unchanged, no error.
- The FSM states are IDLE, DRAIN, FLUSH and RESUME. All outputs are Moore/registered except mem_block, which is combinational from count and state.
- IDLE: stall = fence = 0. On fence_req = 1, latch pc into saved_pc and latch fence_i, then branch:
  - if fence_pred != 0, go to DRAIN;
  - else if fence_i, go to FLUSH;
  - else go to RESUME.
- DRAIN: stall = fence = 1, and the timeout counter increments each cycle. The counter is evaluated with the count as registered at the start of the cycle.
  - count == 0: go to FLUSH if saved fence_i, else RESUME.
  - else, timeout counter == DRAIN_TIMEOUT−1: set err_timeout and take the same exit.
- FLUSH: stall = fence = flush_req = 1. Stay until flush_ack = 1, then go to RESUME. flush_ack in any other state is ignored.
- RESUME: stall = 1, fence = 0, pc_load = 1 for exactly this cycle, resume_pc = saved_pc + 1 (mod 2^32, so 0xFFFFFFFF wraps to 0). Return to IDLE. resume_pc holds its value until the next RESUME.
- fence_req outside IDLE is ignored; decode must re-present it.
- Minimum latency for fence_req at cycle N:
  - pred = 0, not FENCE.I: pc_load at N+1, stall released at N+2.
  - pred != 0, count = 0, not FENCE.I: DRAIN at N+1, RESUME at N+2.
- The timeout counter clears on entry to DRAIN.

Test Plan:
- Reset asserted mid-DRAIN with count = 3 → next sample: state IDLE, stall = 0, outstanding = 0, no pc_load ever issued.
- fence_req with pc = 0x100, pred = 4'b0011, 3 ops outstanding, one mem_done per cycle → stall high, DRAIN lasts exactly until outstanding = 0. Then a single pc_load with resume_pc = 0x101, and err_timeout stays 0.
- FENCE.I with pred = 0, pc = 0x20, flush_ack after 4 cycles → flush_req high 4 cycles, then pc_load with resume_pc = 0x21, fence low during RESUME.
- mem_issue and mem_done together at count = 0 and at count = MAX → count unchanged, err_ovf = 0. Lone issue at MAX → count stays 8 and err_ovf = 1; mem_block is high at MAX.
- DRAIN_TIMEOUT = 4, count stuck at 2 → exactly 4 DRAIN cycles, err_timeout = 1, then RESUME with resume_pc = pc + 1.
- pc = 0xFFFFFFFF with pred = 0 → resume_pc = 0x00000000. A second fence_req during RESUME is ignored, with no second pc_load.
